// File: rtl/p1_bus_cycle_ctl_pkg.sv
// Shared types and timing defaults for the P1 (Multibus) master cycle controller.
// Command code bit 0 is the write flag and bit 1 the I/O-space flag.
package p1_bus_pkg;

  typedef enum logic [2:0] {IDLE, ARB, SETUP, CMD, HOLD, DONE} bus_state_e;

  typedef enum logic [1:0] {MRD = 2'd0, MWT = 2'd1, IOR = 2'd2, IOW = 2'd3} bus_cmd_e;

  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;
  localparam int DEF_TIMEOUT   = 255;
  localparam int DEF_TW        = 8;

  function automatic bus_cmd_e cmd_encode(input logic write, input logic io);
    return bus_cmd_e'({io, write});
  endfunction

  function automatic logic cmd_is_write(input bus_cmd_e c);
    return c[0];
  endfunction

  // Active-low strobe vector ordered {iowc_n, iorc_n, mwtc_n, mrdc_n}
  function automatic logic [3:0] cmd_strobes_n(input bus_cmd_e c);
    return ~(4'b0001 << c);
  endfunction

endpackage

// File: rtl/p1_bus_cycle_ctl_if.sv
// CPU-side request and P1 bus-side signals of the cycle controller.
// The master modport is the controller's view; slave is the environment's.
interface p1_bus_cycle_ctl_if;
  logic cpu_req;
  logic cpu_write;
  logic cpu_io;
  logic p1init;
  logic aen;
  logic xack_n;
  logic sysb;
  logic adr_oe;
  logic dat_oe;
  logic rd_latch;
  logic mrdc_n;
  logic mwtc_n;
  logic iorc_n;
  logic iowc_n;
  logic dtack;
  logic berr;

  modport master (
    input  cpu_req, cpu_write, cpu_io, p1init, aen, xack_n,
    output sysb, adr_oe, dat_oe, rd_latch, mrdc_n, mwtc_n, iorc_n, iowc_n, dtack, berr
  );

  modport slave (
    output cpu_req, cpu_write, cpu_io, p1init, aen, xack_n,
    input  sysb, adr_oe, dat_oe, rd_latch, mrdc_n, mwtc_n, iorc_n, iowc_n, dtack, berr
  );
endinterface

// File: rtl/p1_bus_cycle_ctl_sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module p1_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/p1_bus_cycle_ctl.sv
// Multibus (P1) master cycle controller: arbitrates for the bus, runs one
// MRDC/MWTC/IORC/IOWC cycle with setup/hold timing, and answers dtack or berr.
module p1_bus_cycle_ctl
  import p1_bus_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int TW        = DEF_TW
) (
  input logic                 clk,
  input logic                 rst_n,
  p1_bus_cycle_ctl_if.master  bus
);

  localparam int PMAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int PW   = $clog2(PMAX + 1);

  bus_state_e    state;
  bus_cmd_e      cmd;
  logic [PW-1:0] phase;
  logic [TW-1:0] tmo;
  logic          err;
  logic          req_lost;
  logic          sysb_q;
  logic          adr_oe_q;
  logic          dat_oe_q;
  logic          rd_latch_q;
  logic          dtack_q;
  logic          berr_q;
  logic [3:0]    strobe_n;

  logic xack_raw;
  logic xack_s;
  logic tmo_hit;
  logic grant_lost;
  logic setup_done;
  logic hold_done;
  logic err_now;
  logic answer;

  assign xack_raw = ~bus.xack_n;

  p1_sync2 u_xack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (xack_raw),
    .q     (xack_s)
  );

  assign tmo_hit    = (tmo == TW'(TIMEOUT - 1));
  assign grant_lost = ~bus.aen;
  assign setup_done = (phase == PW'(SETUP_CYC - 1));
  assign hold_done  = (phase == PW'(HOLD_CYC - 1));
  assign err_now    = err | grant_lost;
  // The CPU only gets an answer if it kept its request up for the whole cycle
  assign answer     = bus.cpu_req & ~req_lost;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd        <= MRD;
      phase      <= '0;
      tmo        <= '0;
      err        <= 1'b0;
      req_lost   <= 1'b0;
      sysb_q     <= 1'b0;
      adr_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      rd_latch_q <= 1'b0;
      dtack_q    <= 1'b0;
      berr_q     <= 1'b0;
      strobe_n   <= 4'b1111;
    end else if (bus.p1init) begin
      state      <= IDLE;
      cmd        <= MRD;
      phase      <= '0;
      tmo        <= '0;
      err        <= 1'b0;
      req_lost   <= 1'b0;
      sysb_q     <= 1'b0;
      adr_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      rd_latch_q <= 1'b0;
      dtack_q    <= 1'b0;
      berr_q     <= 1'b0;
      strobe_n   <= 4'b1111;
    end else begin
      rd_latch_q <= 1'b0;
      dtack_q    <= 1'b0;
      berr_q     <= 1'b0;
      if ((state inside {ARB, SETUP, CMD, HOLD}) && !bus.cpu_req) begin
        req_lost <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            cmd      <= cmd_encode(bus.cpu_write, bus.cpu_io);
            sysb_q   <= 1'b1;
            err      <= 1'b0;
            req_lost <= 1'b0;
            state    <= ARB;
          end
        end
        ARB: begin
          if (bus.aen) begin
            adr_oe_q <= 1'b1;
            dat_oe_q <= cmd_is_write(cmd);
            phase    <= '0;
            tmo      <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          tmo <= tmo + 1'b1;
          if (grant_lost || tmo_hit) begin
            err   <= 1'b1;
            phase <= '0;
            state <= HOLD;
          end else if (setup_done && !xack_s) begin
            strobe_n <= cmd_strobes_n(cmd);
            state    <= CMD;
          end else if (!setup_done) begin
            phase <= phase + 1'b1;
          end
        end
        CMD: begin
          tmo <= tmo + 1'b1;
          // XACK is checked ahead of the timeout so a late acknowledge still completes
          if (grant_lost) begin
            err      <= 1'b1;
            strobe_n <= 4'b1111;
            phase    <= '0;
            state    <= HOLD;
          end else if (xack_s) begin
            strobe_n   <= 4'b1111;
            rd_latch_q <= ~cmd_is_write(cmd);
            phase      <= '0;
            state      <= HOLD;
          end else if (tmo_hit) begin
            err      <= 1'b1;
            strobe_n <= 4'b1111;
            phase    <= '0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (grant_lost) begin
            err <= 1'b1;
          end
          if (hold_done) begin
            sysb_q   <= 1'b0;
            adr_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            dtack_q  <= answer & ~err_now;
            berr_q   <= answer & err_now;
            state    <= DONE;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          if (!bus.cpu_req) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sysb     = sysb_q;
  assign bus.adr_oe   = adr_oe_q;
  assign bus.dat_oe   = dat_oe_q;
  assign bus.rd_latch = rd_latch_q;
  assign bus.dtack    = dtack_q;
  assign bus.berr     = berr_q;
  assign {bus.iowc_n, bus.iorc_n, bus.mwtc_n, bus.mrdc_n} = strobe_n;

endmodule

// File: tb/tb_p1_bus_cycle_ctl.sv
// Directed bench for p1_bus_cycle_ctl: per-transaction dtack/berr/rd_latch
// expectations are queued at request time and compared once the cycle finishes.
module tb_p1_bus_cycle_ctl;
  import p1_bus_pkg::*;

  localparam int SETUP_CYC = 3;
  localparam int HOLD_CYC  = 2;
  localparam int TIMEOUT   = 16;
  localparam int TW        = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  p1_bus_cycle_ctl_if bus ();

  p1_bus_cycle_ctl #(
    .SETUP_CYC (SETUP_CYC),
    .HOLD_CYC  (HOLD_CYC),
    .TIMEOUT   (TIMEOUT),
    .TW        (TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [3:0] strb;
  assign strb = {bus.iowc_n, bus.iorc_n, bus.mwtc_n, bus.mrdc_n};

  int total = 0;
  int bad   = 0;
  int dt_cnt = 0, be_cnt = 0, rd_cnt = 0, viol_cnt = 0;

  // Pulse counters and the one-strobe-with-address-driven invariant
  always @(negedge clk) begin
    if (bus.dtack === 1'b1)    dt_cnt++;
    if (bus.berr === 1'b1)     be_cnt++;
    if (bus.rd_latch === 1'b1) rd_cnt++;
    if (strb !== 4'b1111) begin
      if (!$onehot(~strb) || bus.adr_oe !== 1'b1) viol_cnt++;
    end
  end

  typedef struct {
    string tag;
    int    dt;
    int    be;
    int    rd;
  } exp_t;

  exp_t exp_q[$];
  int dt_base, be_base, rd_base;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic wr, input logic io, input logic grant,
                                input int dt, input int be, input int rd);
    exp_t e;
    e.tag = tag;
    e.dt  = dt;
    e.be  = be;
    e.rd  = rd;
    exp_q.push_back(e);
    dt_base = dt_cnt;
    be_base = be_cnt;
    rd_base = rd_cnt;
    bus.cpu_write = wr;
    bus.cpu_io    = io;
    bus.aen       = grant;
    bus.cpu_req   = 1'b1;
  endtask

  task automatic check_result();
    exp_t e;
    check_output("sb_depth", exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_output({e.tag, "_dtack_pulses"}, dt_cnt - dt_base, e.dt);
      check_output({e.tag, "_berr_pulses"},  be_cnt - be_base, e.be);
      check_output({e.tag, "_rdlatch_pulses"}, rd_cnt - rd_base, e.rd);
    end
  endtask

  task automatic wait_strb(input logic [3:0] want, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (strb === want) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    bus.cpu_req   = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_io    = 1'b0;
    bus.p1init    = 1'b0;
    bus.aen       = 1'b0;
    bus.xack_n    = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    check_output("rst_sysb",     bus.sysb,     1'b0);
    check_output("rst_adr_oe",   bus.adr_oe,   1'b0);
    check_output("rst_dat_oe",   bus.dat_oe,   1'b0);
    check_output("rst_rd_latch", bus.rd_latch, 1'b0);
    check_output("rst_strobes",  strb,         4'b1111);
    check_output("rst_dtack",    bus.dtack,    1'b0);
    check_output("rst_berr",     bus.berr,     1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] memory read");
    apply_stimulus("mrd", 1'b0, 1'b0, 1'b0, 1, 0, 1);
    tick();
    check_output("mrd_sysb", bus.sysb, 1'b1);
    tick();
    tick();
    bus.aen = 1'b1;
    tick();
    check_output("mrd_adr_oe", bus.adr_oe, 1'b1);
    check_output("mrd_dat_oe", bus.dat_oe, 1'b0);
    check_output("mrd_strb_setup", strb, 4'b1111);
    wait_strb(4'b1110, 10, n);
    check_output("mrd_setup_len", n, SETUP_CYC);
    tick();
    tick();
    bus.xack_n = 1'b0;
    tick();
    check_output("mrd_strb_sync1", strb, 4'b1110);
    tick();
    check_output("mrd_strb_sync2", strb, 4'b1110);
    tick();
    check_output("mrd_strb_release", strb, 4'b1111);
    check_output("mrd_rd_latch", bus.rd_latch, 1'b1);
    bus.xack_n = 1'b1;
    tick();
    check_output("mrd_rd_latch_off", bus.rd_latch, 1'b0);
    check_output("mrd_hold_adr", bus.adr_oe, 1'b1);
    tick();
    check_output("mrd_done_sysb", bus.sysb, 1'b0);
    check_output("mrd_done_adr", bus.adr_oe, 1'b0);
    check_output("mrd_done_dtack", bus.dtack, 1'b1);
    bus.cpu_req = 1'b0;
    bus.aen     = 1'b0;
    tick();
    check_output("mrd_dtack_end", bus.dtack, 1'b0);
    check_result();

    $display("[TB] io write");
    apply_stimulus("iow", 1'b1, 1'b1, 1'b1, 1, 0, 0);
    tick();
    check_output("iow_arb_adr", bus.adr_oe, 1'b0);
    tick();
    check_output("iow_setup_dat", bus.dat_oe, 1'b1);
    check_output("iow_setup_strb", strb, 4'b1111);
    wait_strb(4'b0111, 10, n);
    check_output("iow_setup_len", n, SETUP_CYC);
    bus.xack_n = 1'b0;
    tick();
    tick();
    check_output("iow_cmd_strb", strb, 4'b0111);
    check_output("iow_cmd_dat", bus.dat_oe, 1'b1);
    tick();
    check_output("iow_hold_strb", strb, 4'b1111);
    check_output("iow_hold_dat", bus.dat_oe, 1'b1);
    check_output("iow_no_rd_latch", bus.rd_latch, 1'b0);
    bus.xack_n = 1'b1;
    tick();
    check_output("iow_hold2_dat", bus.dat_oe, 1'b1);
    tick();
    check_output("iow_done_dat", bus.dat_oe, 1'b0);
    check_output("iow_done_dtack", bus.dtack, 1'b1);
    bus.cpu_req = 1'b0;
    bus.aen     = 1'b0;
    tick();
    check_result();

    $display("[TB] timeout without xack");
    apply_stimulus("tmo", 1'b0, 1'b0, 1'b1, 0, 1, 0);
    tick();
    tick();
    wait_strb(4'b1110, 10, n);
    check_output("tmo_setup_len", n, SETUP_CYC);
    wait_strb(4'b1111, 40, n);
    check_output("tmo_release", n, TIMEOUT - SETUP_CYC);
    check_output("tmo_no_rd_latch", bus.rd_latch, 1'b0);
    tick();
    tick();
    check_output("tmo_berr", bus.berr, 1'b1);
    check_output("tmo_no_dtack", bus.dtack, 1'b0);
    check_output("tmo_done_adr", bus.adr_oe, 1'b0);
    bus.cpu_req = 1'b0;
    bus.aen     = 1'b0;
    tick();
    check_result();

    $display("[TB] stale xack in setup");
    bus.xack_n = 1'b0;
    tick();
    tick();
    tick();
    apply_stimulus("stale", 1'b0, 1'b1, 1'b1, 1, 0, 1);
    tick();
    tick();
    repeat (5) tick();
    check_output("stale_held", strb, 4'b1111);
    bus.xack_n = 1'b1;
    wait_strb(4'b1011, 10, n);
    check_output("stale_delay", n, 3);
    bus.xack_n = 1'b0;
    tick();
    tick();
    tick();
    check_output("stale_release", strb, 4'b1111);
    check_output("stale_rd_latch", bus.rd_latch, 1'b1);
    bus.xack_n = 1'b1;
    tick();
    tick();
    check_output("stale_dtack", bus.dtack, 1'b1);
    bus.cpu_req = 1'b0;
    bus.aen     = 1'b0;
    tick();
    check_result();

    $display("[TB] grant lost in setup");
    apply_stimulus("glost", 1'b1, 1'b0, 1'b1, 0, 1, 0);
    tick();
    tick();
    tick();
    bus.aen = 1'b0;
    tick();
    check_output("glost_strb", strb, 4'b1111);
    check_output("glost_hold_adr", bus.adr_oe, 1'b1);
    tick();
    tick();
    check_output("glost_berr", bus.berr, 1'b1);
    check_output("glost_done_dat", bus.dat_oe, 1'b0);
    bus.cpu_req = 1'b0;
    tick();
    check_result();

    $display("[TB] init mid command");
    apply_stimulus("init", 1'b1, 1'b0, 1'b1, 0, 0, 0);
    tick();
    tick();
    wait_strb(4'b1101, 10, n);
    check_output("init_setup_len", n, SETUP_CYC);
    tick();
    bus.p1init  = 1'b1;
    bus.cpu_req = 1'b0;
    tick();
    check_output("init_strb", strb, 4'b1111);
    check_output("init_adr", bus.adr_oe, 1'b0);
    check_output("init_dat", bus.dat_oe, 1'b0);
    check_output("init_sysb", bus.sysb, 1'b0);
    check_output("init_dtack", bus.dtack, 1'b0);
    check_output("init_berr", bus.berr, 1'b0);
    bus.p1init = 1'b0;
    bus.aen    = 1'b0;
    tick();
    tick();
    check_output("init_idle_sysb", bus.sysb, 1'b0);
    check_result();

    $display("[TB] request dropped in command");
    apply_stimulus("drop", 1'b0, 1'b0, 1'b1, 0, 0, 1);
    tick();
    tick();
    wait_strb(4'b1110, 10, n);
    check_output("drop_setup_len", n, SETUP_CYC);
    bus.cpu_req = 1'b0;
    tick();
    check_output("drop_cmd_kept", strb, 4'b1110);
    bus.xack_n = 1'b0;
    tick();
    tick();
    tick();
    check_output("drop_release", strb, 4'b1111);
    check_output("drop_rd_latch", bus.rd_latch, 1'b1);
    bus.xack_n = 1'b1;
    tick();
    tick();
    check_output("drop_done_adr", bus.adr_oe, 1'b0);
    check_output("drop_no_dtack", bus.dtack, 1'b0);
    bus.aen = 1'b0;
    tick();
    check_result();

    $display("[TB] reset mid cycle");
    apply_stimulus("rst", 1'b0, 1'b1, 1'b1, 0, 0, 0);
    tick();
    check_output("rst_from_idle_sysb", bus.sysb, 1'b1);
    tick();
    wait_strb(4'b1011, 10, n);
    check_output("rst_setup_len", n, SETUP_CYC);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_async_strb", strb, 4'b1111);
    check_output("rst_async_adr", bus.adr_oe, 1'b0);
    check_output("rst_async_sysb", bus.sysb, 1'b0);
    bus.cpu_req = 1'b0;
    bus.aen     = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_output("rst_after_sysb", bus.sysb, 1'b0);
    check_result();

    check_output("invariant_violations", viol_cnt, 0);
    check_output("sb_leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
